// File: rtl/pc_seq_pkg.sv
// Shared types and default sizing for the program-counter sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } seq_state_t;

    typedef enum logic [2:0] {
        SEL_HOLD = 3'd0,
        SEL_INC  = 3'd1,
        SEL_BR   = 3'd2,
        SEL_JMP  = 3'd3,
        SEL_CALL = 3'd4,
        SEL_RET  = 3'd5
    } next_sel_t;

    localparam int PSIZE_DEF     = 5;
    localparam int LAST_ADDR_DEF = 30;
    localparam int DEPTH_DEF     = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-flow request / status bundle between the CPU decode stage and the sequencer.
interface pc_sequencer_if #(
    parameter int Psize = 5,
    parameter int Depth = 4
);
    logic                       Stall;
    logic                       HaltReq;
    logic                       BranchTaken;
    logic [Psize-1:0]           BranchOffset;
    logic                       Jump;
    logic                       Call;
    logic                       Ret;
    logic [Psize-1:0]           Target;
    logic [Psize-1:0]           ProgAddress;
    logic                       Halted;
    logic                       StackErr;
    logic [$clog2(Depth):0]     StackLevel;

    modport master (
        output Stall, HaltReq, BranchTaken, BranchOffset, Jump, Call, Ret, Target,
        input  ProgAddress, Halted, StackErr, StackLevel
    );

    modport slave (
        input  Stall, HaltReq, BranchTaken, BranchOffset, Jump, Call, Ret, Target,
        output ProgAddress, Halted, StackErr, StackLevel
    );
endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address stack; Top is the most recently pushed entry, valid only when not Empty.
module ret_stack
    import pc_seq_pkg::*;
#(
    parameter int Psize = PSIZE_DEF,
    parameter int Depth = DEPTH_DEF,
    localparam int IW   = $clog2(Depth),
    localparam int LW   = IW + 1
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             Push,
    input  logic             Pop,
    input  logic [Psize-1:0] DataIn,
    output logic [Psize-1:0] Top,
    output logic [LW-1:0]    Level,
    output logic             Full,
    output logic             Empty
);

    logic [LW-1:0]    level_reg;
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;
    logic             do_push;
    logic             do_pop;
    logic [Psize-1:0] slot [Depth];

    assign Full    = (level_reg == LW'(Depth));
    assign Empty   = (level_reg == '0);
    assign do_push = Push && !Full;
    assign do_pop  = Pop && !Push && !Empty;
    assign wr_idx  = level_reg[IW-1:0];
    assign rd_idx  = wr_idx - IW'(1);
    assign Top     = slot[rd_idx];
    assign Level   = level_reg;

    // Only the level is reset; entry contents are meaningless until pushed.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            level_reg <= '0;
        end else if (do_push) begin
            level_reg <= level_reg + LW'(1);
        end else if (do_pop) begin
            level_reg <= level_reg - LW'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < Depth; gi++) begin : g_slot
            logic [Psize-1:0] slot_reg;
            always_ff @(posedge Clock) begin
                if (do_push && wr_idx == IW'(gi)) begin
                    slot_reg <= DataIn;
                end
            end
            assign slot[gi] = slot_reg;
        end
    endgenerate

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with prioritised next-address selection, return stack, halt and fault states.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int Psize    = PSIZE_DEF,
    parameter int LastAddr = LAST_ADDR_DEF,
    parameter int Depth    = DEPTH_DEF
) (
    input  logic                 Clock,
    input  logic                 nReset,
    pc_sequencer_if.slave        bus
);

    localparam int LW = $clog2(Depth) + 1;
    localparam logic [Psize-1:0] LAST = Psize'(LastAddr);

    seq_state_t       state_reg, state_next;
    next_sel_t        sel;
    logic [Psize-1:0] pc_reg, pc_next;
    logic [Psize-1:0] pc_inc;
    logic             push, pop;
    logic [Psize-1:0] stack_top;
    logic [LW-1:0]    stack_level;
    logic             stack_full, stack_empty;

    // Sequential increment and the call return address share the same wrap rule.
    assign pc_inc = (pc_reg == LAST) ? '0 : pc_reg + Psize'(1);

    ret_stack #(.Psize(Psize), .Depth(Depth)) u_stack (
        .Clock  (Clock),
        .nReset (nReset),
        .Push   (push),
        .Pop    (pop),
        .DataIn (pc_inc),
        .Top    (stack_top),
        .Level  (stack_level),
        .Full   (stack_full),
        .Empty  (stack_empty)
    );

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_reg <= RUN;
            pc_reg    <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sel        = SEL_HOLD;
        push       = 1'b0;
        pop        = 1'b0;
        if (state_reg == RUN && !bus.Stall) begin
            if (bus.HaltReq) begin
                state_next = HALT;
            end else if (bus.Ret) begin
                if (stack_empty) state_next = FAULT;
                else begin
                    sel = SEL_RET;
                    pop = 1'b1;
                end
            end else if (bus.Call) begin
                if (stack_full) state_next = FAULT;
                else begin
                    sel  = SEL_CALL;
                    push = 1'b1;
                end
            end else if (bus.Jump) begin
                sel = SEL_JMP;
            end else if (bus.BranchTaken) begin
                sel = SEL_BR;
            end else begin
                sel = SEL_INC;
            end
        end

        // Branch target wraps modulo 2^Psize and deliberately skips the LastAddr check.
        case (sel)
            SEL_INC:           pc_next = pc_inc;
            SEL_BR:            pc_next = pc_reg + bus.BranchOffset;
            SEL_JMP, SEL_CALL: pc_next = bus.Target;
            SEL_RET:           pc_next = stack_top;
            default:           pc_next = pc_reg;
        endcase
    end

    always_comb begin
        bus.ProgAddress = pc_reg;
        bus.Halted      = (state_reg == HALT);
        bus.StackErr    = (state_reg == FAULT);
        bus.StackLevel  = stack_level;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: each step queues the expected post-edge state, then checks it.
module tb_pc_sequencer;

    logic Clock = 1'b0;
    logic nReset;

    always #5 Clock = ~Clock;

    pc_sequencer_if #(.Psize(5), .Depth(4)) bus ();

    pc_sequencer #(.Psize(5), .LastAddr(30), .Depth(4)) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (bus)
    );

    typedef struct {
        logic [4:0] pc;
        logic [2:0] lvl;
        logic       halted;
        logic       err;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic clr();
        bus.Stall        = 1'b0;
        bus.HaltReq      = 1'b0;
        bus.BranchTaken  = 1'b0;
        bus.BranchOffset = '0;
        bus.Jump         = 1'b0;
        bus.Call         = 1'b0;
        bus.Ret          = 1'b0;
        bus.Target       = '0;
    endtask

    task automatic cyc(input string tag, input logic [4:0] pc, input logic [2:0] lvl,
                       input logic halted, input logic err);
        exp_t e;
        exp_t got;
        e.pc = pc; e.lvl = lvl; e.halted = halted; e.err = err; e.tag = tag;
        exp_q.push_back(e);
        @(posedge Clock);
        #1;
        got = exp_q.pop_front();
        tests++;
        assert (bus.ProgAddress === got.pc) else begin
            fails++;
            $error("FAIL %s ProgAddress got %0d expected %0d", got.tag, bus.ProgAddress, got.pc);
        end
        tests++;
        assert (bus.StackLevel === got.lvl) else begin
            fails++;
            $error("FAIL %s StackLevel got %0d expected %0d", got.tag, bus.StackLevel, got.lvl);
        end
        tests++;
        assert (bus.Halted === got.halted) else begin
            fails++;
            $error("FAIL %s Halted got %b expected %b", got.tag, bus.Halted, got.halted);
        end
        tests++;
        assert (bus.StackErr === got.err) else begin
            fails++;
            $error("FAIL %s StackErr got %b expected %b", got.tag, bus.StackErr, got.err);
        end
        $display("[TB] %s pc=%0d lvl=%0d halted=%b err=%b", tag, bus.ProgAddress,
                 bus.StackLevel, bus.Halted, bus.StackErr);
    endtask

    task automatic do_reset();
        clr();
        nReset = 1'b0;
        cyc("reset", 5'd0, 3'd0, 1'b0, 1'b0);
        nReset = 1'b1;
    endtask

    task automatic jump_to(input logic [4:0] t);
        clr();
        bus.Jump = 1'b1; bus.Target = t;
        cyc("jump", t, 3'd0, 1'b0, 1'b0);
        clr();
    endtask

    initial begin
        clr();
        nReset = 1'b0;
        @(posedge Clock);
        do_reset();

        // Free run: wraps after LastAddr, 31 never appears
        for (int i = 1; i <= 32; i++) cyc("freerun", 5'(i % 31), 3'd0, 1'b0, 1'b0);

        // Branch / jump priority
        do_reset();
        jump_to(5'd5);
        bus.BranchTaken = 1'b1; bus.BranchOffset = 5'b11101;
        cyc("branch_neg", 5'd2, 3'd0, 1'b0, 1'b0);
        jump_to(5'd3);
        bus.BranchTaken = 1'b1; bus.BranchOffset = 5'd4; bus.Jump = 1'b1; bus.Target = 5'd20;
        cyc("jump_over_branch", 5'd20, 3'd0, 1'b0, 1'b0);
        clr();
        bus.BranchTaken = 1'b1; bus.BranchOffset = 5'd11;
        cyc("branch_past_last", 5'd31, 3'd0, 1'b0, 1'b0);
        clr();
        cyc("inc_from_31", 5'd0, 3'd0, 1'b0, 1'b0);

        // Call / return
        jump_to(5'd7);
        bus.Call = 1'b1; bus.Target = 5'd12;
        cyc("call", 5'd12, 3'd1, 1'b0, 1'b0);
        clr(); bus.Ret = 1'b1;
        cyc("ret", 5'd8, 3'd0, 1'b0, 1'b0);
        jump_to(5'd30);
        bus.Call = 1'b1; bus.Target = 5'd4;
        cyc("call_at_last", 5'd4, 3'd1, 1'b0, 1'b0);
        clr(); bus.Ret = 1'b1;
        cyc("ret_wrap", 5'd0, 3'd0, 1'b0, 1'b0);

        // Nested calls: LIFO order then underflow
        do_reset();
        bus.Call = 1'b1; bus.Target = 5'd20;
        cyc("nest_call1", 5'd20, 3'd1, 1'b0, 1'b0);
        bus.Target = 5'd25;
        cyc("nest_call2", 5'd25, 3'd2, 1'b0, 1'b0);
        clr(); bus.Ret = 1'b1;
        cyc("nest_ret1", 5'd21, 3'd1, 1'b0, 1'b0);
        cyc("nest_ret2", 5'd1, 3'd0, 1'b0, 1'b0);
        cyc("underflow", 5'd1, 3'd0, 1'b0, 1'b1);

        // Overflow on the fifth call
        do_reset();
        bus.Call = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.Target = 5'(10 + i);
            cyc("call_fill", 5'(10 + i), 3'(i + 1), 1'b0, 1'b0);
        end
        bus.Target = 5'd14;
        cyc("overflow", 5'd13, 3'd4, 1'b0, 1'b1);
        clr(); bus.Ret = 1'b1;
        cyc("fault_sticky", 5'd13, 3'd4, 1'b0, 1'b1);

        // Ret straight out of reset
        do_reset();
        bus.Ret = 1'b1;
        cyc("ret_from_reset", 5'd0, 3'd0, 1'b0, 1'b1);

        // Stall freezes everything, HaltReq included
        do_reset();
        jump_to(5'd9);
        bus.Stall = 1'b1; bus.Jump = 1'b1; bus.Target = 5'd2;
        cyc("stall1", 5'd9, 3'd0, 1'b0, 1'b0);
        cyc("stall2", 5'd9, 3'd0, 1'b0, 1'b0);
        bus.HaltReq = 1'b1;
        cyc("stall3", 5'd9, 3'd0, 1'b0, 1'b0);
        bus.Stall = 1'b0; bus.HaltReq = 1'b0;
        cyc("stall_release", 5'd2, 3'd0, 1'b0, 1'b0);

        // Halt beats call, inputs ignored, reset recovers
        jump_to(5'd13);
        bus.Call = 1'b1; bus.Target = 5'd14;
        cyc("call_pre_halt", 5'd14, 3'd1, 1'b0, 1'b0);
        bus.HaltReq = 1'b1; bus.Target = 5'd3;
        cyc("halt", 5'd14, 3'd1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.Stall        = 1'($urandom_range(0, 1));
            bus.HaltReq      = 1'($urandom_range(0, 1));
            bus.BranchTaken  = 1'($urandom_range(0, 1));
            bus.BranchOffset = 5'($urandom_range(0, 31));
            bus.Jump         = 1'($urandom_range(0, 1));
            bus.Call         = 1'($urandom_range(0, 1));
            bus.Ret          = 1'($urandom_range(0, 1));
            bus.Target       = 5'($urandom_range(0, 31));
            cyc("halt_hold", 5'd14, 3'd1, 1'b1, 1'b0);
        end
        nReset = 1'b0;
        cyc("reset_from_halt", 5'd0, 3'd0, 1'b0, 1'b0);
        nReset = 1'b1;
        clr();
        cyc("run_after_reset", 5'd1, 3'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and control-flow sequencer for the single-cycle CPU. Drives the address input of the program memory (5-bit address, 20-bit instruction, 31 populated words at 0..30).
- Each cycle it selects the next fetch address from: increment, relative branch, absolute jump, call, or return.
- Holds a small hardware return-address stack. Supports stall, halt and a fault state for stack misuse.

Parameters:
- Psize, 5, program address width; must match the program memory address width.
- LastAddr, 30, highest populated program address; sequential increment past it wraps to 0.
- Depth, 4, return-address stack entries (power of two, at least 2).

Ports:
- Clock  input  1  system clock, rising edge.
- nReset  input  1  synchronous, active-low reset.
- Stall  input  1  freeze PC, stack and state this cycle.
- HaltReq  input  1  enter HALT after this instruction.
- BranchTaken  input  1  relative branch: PC <= PC + BranchOffset.
- BranchOffset  input  Psize  two's-complement offset.
- Jump  input  1  absolute jump: PC <= Target.
- Call  input  1  push PC+1, then PC <= Target.
- Ret  input  1  pop top of stack into PC.
- Target  input  Psize  jump/call destination.
- ProgAddress  output  Psize  current fetch address (registered PC).
- Halted  output  1  high in HALT.
- StackErr  output  1  high in FAULT (sticky until reset).
- StackLevel  output  $clog2(Depth)+1  number of valid stack entries.

Behaviour:
- Reset:
  - On a rising Clock with nReset=0: PC=0, state=RUN, StackLevel=0, Halted=0, StackErr=0.
  - Stack contents are don't-care after reset.
  - Reset takes effect mid-operation from any state, including HALT and FAULT.
- Timing:
  - ProgAddress is combinationally equal to the PC register.
  - Any control input sampled at edge N takes effect on ProgAddress from edge N onward, i.e. 1-cycle next-PC latency.
- States:
  - RUN: normal operation.
  - HALT: PC frozen; exits only via reset.
  - FAULT: PC frozen; exits only via reset.
- Priority in RUN when Stall=0, highest first:
  - HaltReq: go to HALT; PC unchanged.
  - Ret: pop the stack.
  - Call: push.
  - Jump.
  - BranchTaken.
  - Otherwise sequential increment.
  - Lower-priority requests asserted in the same cycle are ignored.
- Sequential increment: if PC == LastAddr then 0, else PC+1.
- Call return address: the same wrap rule as sequential increment.
- Branch: PC + BranchOffset computed modulo 2^Psize. No LastAddr check; a target above LastAddr is fetched as-is. Memory returns unknown data there, which is a software error.
- Jump/Call: PC <= Target unchanged.
- Stack:
  - Push writes entry[StackLevel] and increments StackLevel.
  - Pop reads entry[StackLevel-1] and decrements StackLevel.
  - Call with StackLevel==Depth (overflow): no push, PC unchanged, go to FAULT.
  - Ret with StackLevel==0 (underflow): no pop, PC unchanged, go to FAULT.
- Stall=1 in RUN: PC, stack and state all hold; every other control input is ignored, including HaltReq.
- Halted and StackErr are decoded directly from the state register, so they are registered outputs.
- In HALT and FAULT, Stall and all control inputs are ignored.

Decomposition:
- Package pc_seq_pkg holds:
  - enum type seq_state_t {RUN, HALT, FAULT}, 2 bits;
  - enum next_sel_t {SEL_HOLD, SEL_INC, SEL_BR, SEL_JMP, SEL_CALL, SEL_RET} for the next-PC mux;
  - default constants for Psize, LastAddr and Depth.
- Sub-module ret_stack (Psize, Depth):
  - inputs: Push, Pop, DataIn;
  - outputs: Top, Level, Full, Empty;
  - synchronous active-low reset of Level only.
- pc_sequencer contains the state register, PC register, priority decode and next-PC mux.

Test Plan:
- Reset then 32 free-running cycles -> ProgAddress 0,1,...,30,0,1. Wrap occurs after 30; address 31 never appears.
- PC=5, BranchTaken=1, BranchOffset=5'b11101 (-3) -> PC=2. PC=3, offset +4 with Jump=1 and Target=20 same cycle -> PC=20 (Jump wins).
- PC=7, Call=1, Target=12 -> PC=12, StackLevel=1. Then Ret=1 -> PC=8, StackLevel=0. Call at PC=30 -> pushed value is 0.
- Four nested Calls succeed (StackLevel=4). A fifth Call -> state FAULT, StackErr=1, PC frozen at the fifth call site. Separately, Ret from reset -> FAULT, PC=0.
- Stall=1 for 3 cycles at PC=9 with Jump=1 and Target=2 -> PC stays 9. Stall drops with Jump still high -> PC=2 next edge.
- HaltReq=1 at PC=14 together with Call=1 -> Halted=1, PC=14, StackLevel unchanged. Inputs toggled for 5 cycles have no effect. nReset=0 for one edge -> PC=0, Halted=0, RUN.
